// File: rtl/vending_machine_param.sv
// Multi-item vending controller: coin credit accumulation, priced purchases, unit-pulse change return.
// Optional VM_AUTO_CHANGE_EN: return leftover credit automatically after a vend instead of retaining it.
module vending_machine_param #(
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 20,
    parameter int N_ITEMS    = 2,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {8'd5, 8'd3},
    parameter int SEL_W      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_vld,
    input  logic [CREDIT_W-1:0] coin_val,
    input  logic                buy,
    input  logic [SEL_W-1:0]    item_sel,
    input  logic                cancel,
    output logic                vend,
    output logic [SEL_W-1:0]    vend_item,
    output logic                ret_pulse,
    output logic                coin_rej,
    output logic                buy_rej,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    // state    | meaning
    // S_IDLE   | no credit held
    // S_CREDIT | credit > 0, accepting coins / purchases
    // S_VEND   | single dispense cycle
    // S_CHANGE | returning one credit unit per cycle
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                vend_q, vend_d;
    logic [SEL_W-1:0]    vend_item_q, vend_item_d;
    logic                ret_pulse_q, ret_pulse_d;
    logic                coin_rej_q, coin_rej_d;
    logic                buy_rej_q, buy_rej_d;
    logic                busy_q, busy_d;

    logic [CREDIT_W-1:0] price_sel;
    logic                sel_ok;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic                afford;

    always_comb begin
        price_sel = '0;
        sel_ok    = 1'b0;
        for (int k = 0; k < N_ITEMS; k++) begin
            if (int'(item_sel) == k) begin
                sel_ok    = 1'b1;
                price_sel = PRICES[k*CREDIT_W +: CREDIT_W];
            end
        end
    end

    // Extra carry bit keeps the overflow test honest near 2^CREDIT_W.
    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_ok  = (coin_sum <= MAX_SUM);
    assign afford   = (credit_q >= price_sel);

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        vend_d      = 1'b0;
        vend_item_d = vend_item_q;
        coin_rej_d  = 1'b0;
        buy_rej_d   = 1'b0;

        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (cancel) begin
                    if (credit_q != '0) begin
                        state_d = S_CHANGE;
                    end
                end else if (coin_vld) begin
                    if (coin_ok) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = (coin_sum == '0) ? S_IDLE : S_CREDIT;
                    end else begin
                        coin_rej_d = 1'b1;
                    end
                end else if (buy) begin
                    if (sel_ok && afford) begin
                        credit_d    = credit_q - price_sel;
                        vend_item_d = item_sel;
                        vend_d      = 1'b1;
                        state_d     = S_VEND;
                    end else begin
                        buy_rej_d = 1'b1;
                    end
                end
            end
            S_VEND: begin
                coin_rej_d = coin_vld;
                if (credit_q == '0) begin
                    state_d = S_IDLE;
                end else begin
`ifdef VM_AUTO_CHANGE_EN
                    state_d = S_CHANGE;
`else
                    state_d = S_CREDIT;
`endif
                end
            end
            S_CHANGE: begin
                coin_rej_d = coin_vld;
                if (credit_q <= CREDIT_W'(1)) begin
                    credit_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    credit_d = credit_q - CREDIT_W'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase

        // A pulse is issued for every cycle spent in CHANGE, including the first.
        ret_pulse_d = (state_d == S_CHANGE);
        busy_d      = (state_d == S_VEND) || (state_d == S_CHANGE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            credit_q    <= '0;
            vend_q      <= 1'b0;
            vend_item_q <= '0;
            ret_pulse_q <= 1'b0;
            coin_rej_q  <= 1'b0;
            buy_rej_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            vend_q      <= vend_d;
            vend_item_q <= vend_item_d;
            ret_pulse_q <= ret_pulse_d;
            coin_rej_q  <= coin_rej_d;
            buy_rej_q   <= buy_rej_d;
            busy_q      <= busy_d;
        end
    end

    assign vend      = vend_q;
    assign vend_item = vend_item_q;
    assign ret_pulse = ret_pulse_q;
    assign coin_rej  = coin_rej_q;
    assign buy_rej   = buy_rej_q;
    assign credit    = credit_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: directed scenarios plus random traffic against an integer credit model.
module tb_vending_machine_param;

    localparam int CW   = 8;
    localparam int MAXC = 20;
    localparam int NI   = 3;
    localparam int SW   = 2;
`ifdef VM_AUTO_CHANGE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          coin_vld;
    logic [CW-1:0] coin_val;
    logic          buy;
    logic [SW-1:0] item_sel;
    logic          cancel;
    logic          vend;
    logic [SW-1:0] vend_item;
    logic          ret_pulse;
    logic          coin_rej;
    logic          buy_rej;
    logic [CW-1:0] credit;
    logic          busy;

    int checks = 0;
    int passes = 0;

    int price [NI] = '{3, 5, 4};

    vending_machine_param #(
        .CREDIT_W  (CW),
        .MAX_CREDIT(MAXC),
        .N_ITEMS   (NI),
        .PRICES    ({8'd4, 8'd5, 8'd3})
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .coin_vld (coin_vld),
        .coin_val (coin_val),
        .buy      (buy),
        .item_sel (item_sel),
        .cancel   (cancel),
        .vend     (vend),
        .vend_item(vend_item),
        .ret_pulse(ret_pulse),
        .coin_rej (coin_rej),
        .buy_rej  (buy_rej),
        .credit   (credit),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference: credit as an integer, "vending" and "refunding" as plain flags.
    int m_credit = 0;
    bit m_vend = 0, m_ret = 0, m_crej = 0, m_brej = 0;
    int m_item = 0;

    always @(posedge clk or negedge rst_n) begin
        bit was_vend, was_ret;
        if (!rst_n) begin
            m_credit = 0; m_vend = 0; m_ret = 0; m_crej = 0; m_brej = 0; m_item = 0;
        end else begin
            was_vend = m_vend;
            was_ret  = m_ret;
            m_vend = 0; m_ret = 0; m_crej = 0; m_brej = 0;
            if (was_vend) begin
                m_crej = coin_vld;
                if (AUTO && m_credit > 0) m_ret = 1;
            end else if (was_ret) begin
                m_crej   = coin_vld;
                m_credit = m_credit - 1;
                m_ret    = (m_credit > 0);
            end else if (cancel) begin
                m_ret = (m_credit > 0);
            end else if (coin_vld) begin
                if (m_credit + int'(coin_val) <= MAXC) m_credit = m_credit + int'(coin_val);
                else m_crej = 1;
            end else if (buy) begin
                m_brej = 1;
                if (int'(item_sel) < NI) begin
                    if (m_credit >= price[int'(item_sel)]) begin
                        m_credit = m_credit - price[int'(item_sel)];
                        m_item   = int'(item_sel);
                        m_vend   = 1;
                        m_brej   = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (vend !== m_vend || (m_vend && int'(vend_item) != m_item) || ret_pulse !== m_ret ||
            coin_rej !== m_crej || buy_rej !== m_brej || credit !== CW'(m_credit) ||
            busy !== (m_vend || m_ret)) begin
            $display("FAIL cycle t=%0t: got vend=%0b item=%0d ret=%0b crej=%0b brej=%0b credit=%0d busy=%0b, expected vend=%0b item=%0d ret=%0b crej=%0b brej=%0b credit=%0d busy=%0b",
                     $time, vend, vend_item, ret_pulse, coin_rej, buy_rej, credit, busy,
                     m_vend, m_item, m_ret, m_crej, m_brej, m_credit, m_vend || m_ret);
        end else begin
            passes++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else passes++;
    endtask

    task automatic cyc(input bit c, input bit cv, input int v, input bit b, input int s);
        @(negedge clk);
        cancel   = c;
        coin_vld = cv;
        coin_val = CW'(v);
        buy      = b;
        item_sel = SW'(s);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic coin(input int v);
        cyc(0, 1, v, 0, 0);
    endtask

    task automatic drain();
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 30; i++) idle();
        chk("drain_credit", int'(credit), 0);
    endtask

    initial begin
        int n, first, last;
        rst_n = 1'b0;
        cancel = 0; coin_vld = 0; coin_val = '0; buy = 0; item_sel = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        idle();
        chk("rst_credit", int'(credit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_vend", int'(vend), 0);
        chk("rst_ret", int'(ret_pulse), 0);

        coin(9); coin(9); idle();
        chk("credit_18", int'(credit), 18);
        coin(5); idle();
        chk("ovf_rej", int'(coin_rej), 1);
        chk("ovf_credit", int'(credit), 18);
        idle();
        chk("rej_one_cycle", int'(coin_rej), 0);
        coin(2); idle();
        chk("credit_20", int'(credit), 20);

        cyc(1, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 25; i++) begin
            idle();
            if (ret_pulse) n++;
        end
        chk("refund_20_pulses", n, 20);
        chk("refund_credit", int'(credit), 0);

        coin(4);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 3);
        chk("buy_poor_rej", int'(buy_rej), 1);
        chk("buy_poor_credit", int'(credit), 4);
        idle();
        chk("buy_badsel_rej", int'(buy_rej), 1);
        chk("buy_badsel_credit", int'(credit), 4);

        cyc(0, 1, 3, 1, 0); idle();
        chk("coin_beats_buy_credit", int'(credit), 7);
        chk("coin_beats_buy_vend", int'(vend), 0);
        chk("coin_beats_buy_rej", int'(buy_rej), 0);

        coin(3);
        cyc(0, 0, 0, 1, 0);
        coin(1);
        chk("vend_pulse", int'(vend), 1);
        chk("vend_item", int'(vend_item), 0);
        chk("vend_credit", int'(credit), 7);
        chk("vend_busy", int'(busy), 1);
        idle();
        chk("vend_coin_rej", int'(coin_rej), 1);
        chk("vend_done", int'(vend), 0);
        chk("post_vend_ret", int'(ret_pulse), AUTO ? 1 : 0);
        chk("post_vend_busy", int'(busy), AUTO ? 1 : 0);
        chk("post_vend_credit", int'(credit), 7);
        drain();

        coin(6);
        cyc(1, 1, 2, 1, 0);
        n = 0; first = -1; last = -1;
        for (int i = 0; i < 10; i++) begin
            idle();
            if (ret_pulse) begin
                n++;
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("cancel6_pulses", n, 6);
        chk("cancel6_first", first, 0);
        chk("cancel6_span", last - first, 5);
        chk("cancel6_credit", int'(credit), 0);

        coin(2); coin(2); idle();
        chk("auto_credit_4", int'(credit), 4);
        cyc(0, 0, 0, 1, 0); idle();
        chk("auto_vend", int'(vend), 1);
        chk("auto_vend_item", int'(vend_item), 0);
        chk("auto_vend_credit", int'(credit), 1);
        idle();
        chk("auto_ret", int'(ret_pulse), AUTO ? 1 : 0);
        idle();
        chk("auto_ret_end", int'(ret_pulse), 0);
        chk("auto_final_credit", int'(credit), AUTO ? 0 : 1);
        chk("auto_final_busy", int'(busy), 0);
        drain();

        coin(3);
        cyc(1, 0, 0, 0, 0);
        idle();
        chk("chg_ret1", int'(ret_pulse), 1);
        chk("chg_credit3", int'(credit), 3);
        idle();
        chk("chg_credit2", int'(credit), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_credit", int'(credit), 0);
        chk("rstmid_ret", int'(ret_pulse), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_vend", int'(vend), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (ret_pulse) n++;
        end
        chk("rstmid_no_more_ret", n, 0);
        chk("rstmid_idle_credit", int'(credit), 0);

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            cyc(r < 4, (r >= 4 && r < 45) || r > 94, int'($urandom_range(0, 8)),
                r >= 40 && r < 80, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #5 rst_n = 1'b1;
            end
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vending_machine_param.md
# vending_machine_param

Parametrised multi-item vending controller, successor to the fixed single-product coffee FSM. It accumulates coin credit of arbitrary denomination and sells one of `N_ITEMS` products at per-item prices. It returns change as a unit-pulse train and rejects overflowing coins and unaffordable or invalid purchases. It sits between the coin acceptor and keypad front-end and the dispenser and change-hopper drivers.

## Interface
- `CREDIT_W`, 8: width of credit, coin value and price fields.
- `MAX_CREDIT`, 20: maximum credit held, in units; must be < 2^CREDIT_W.
- `N_ITEMS`, 2: number of products, ≥1.
- `PRICES`, {8'd5, 8'd3}: packed `N_ITEMS*CREDIT_W` vector; item k price is `PRICES[k*CREDIT_W +: CREDIT_W]`, each nonzero.
- `SEL_W`: derived, `max(1, $clog2(N_ITEMS))`.

- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `coin_vld` input 1: coin present this cycle.
- `coin_val` input CREDIT_W: coin value in units, sampled with `coin_vld`.
- `buy` input 1: purchase request.
- `item_sel` input SEL_W: product index, sampled with `buy`.
- `cancel` input 1: refund all credit.
- `vend` output 1: one-cycle dispense pulse.
- `vend_item` output SEL_W: product index, valid while `vend`=1.
- `ret_pulse` output 1: one unit of change returned per high cycle.
- `coin_rej` output 1: one-cycle pulse, coin refused.
- `buy_rej` output 1: one-cycle pulse, purchase refused.
- `credit` output CREDIT_W: current credit.
- `busy` output 1: high in VEND or CHANGE.

## Operation
- States: IDLE (credit=0), CREDIT (credit>0), VEND, CHANGE.
- Priority in IDLE/CREDIT: `cancel` > `coin_vld` > `buy`. A lower-priority request in the same cycle is dropped silently, with no reject pulse.
- `cancel`: if credit>0, go to CHANGE; else no effect.
- Coin: if credit+coin_val ≤ MAX_CREDIT, credit += coin_val and go to CREDIT. Otherwise `coin_rej` pulses and credit is unchanged. `coin_val`=0 is accepted with no effect. Compute the sum at CREDIT_W+1 bits so it cannot wrap.
- Buy: if item_sel < N_ITEMS and credit ≥ price, credit -= price, latch `vend_item`, and go to VEND. Otherwise `buy_rej` pulses and state and credit are unchanged.
- VEND lasts one cycle with `vend`=1. Exit is per Configuration; it goes to IDLE if credit=0.
- CHANGE: each cycle `ret_pulse`=1 and credit -= 1. When credit reaches 0, go to IDLE. Exactly N pulses are issued for N units of entry credit, back to back.
- In VEND or CHANGE: `coin_vld` gives `coin_rej`. `buy` and `cancel` are ignored.
- `rst_n` low at any time, including mid-CHANGE, forces IDLE and zeroes all outputs. Undelivered change is forfeited.

## Timing
- All outputs are registered. Reset value of every output is 0; state is IDLE.
- A request sampled at edge t takes effect in `credit`, `coin_rej` and `buy_rej` after edge t.
- `vend` is high for the single cycle after the `buy` edge. `credit` already shows the post-price value in that cycle.
- The first `ret_pulse` is in the cycle after entering CHANGE. From a cancel or vend at edge t, pulses occupy cycles t+1..t+N (cancel) or t+2..t+N+1 (vend).
- Reject pulses are exactly one cycle and may occur on consecutive cycles.
- `busy` equals (state==VEND or state==CHANGE), registered with the state.

## Configuration
- `VM_AUTO_CHANGE_EN` defined: after VEND, remaining credit>0 goes to CHANGE and is returned automatically.
- Undefined: after VEND, remaining credit>0 goes to CREDIT and is retained for further purchases. It is returned only on `cancel`.

## Test plan
- Reset mid-CHANGE with credit=3, `rst_n` low one cycle -> all outputs 0, IDLE, no further `ret_pulse`.
- Coins 2,2, then buy item 0 (price 3), with VM_AUTO_CHANGE_EN -> credit 4, `vend`=1 with `vend_item`=0 and credit 1, then one `ret_pulse`, IDLE.
- Credit 18, coin 5 -> `coin_rej` one cycle, credit stays 18. Then coin 2 -> credit 20.
- Credit 4, buy item 1 (price 5) -> `buy_rej`, credit 4. Buy with item_sel ≥ N_ITEMS (N_ITEMS=3 build) -> `buy_rej`.
- Same cycle `coin_vld`(3) and `buy` -> credit +3, no vend, no `buy_rej`. Same cycle `cancel`, coin and buy at credit 6 -> six consecutive `ret_pulse`, coin dropped.
- Without VM_AUTO_CHANGE_EN: credit 10, buy item 0 -> `vend`, credit 7, state CREDIT, no `ret_pulse`. A coin during VEND -> `coin_rej`.
